// File: rtl/vga_timing_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Shared types, 640x480@60 default timing constants and helper
//             functions for the VGA raster sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Segment of a raster axis a counter value falls into
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    // Run/stop control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // 640x480@60 defaults
    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;
    localparam bit c_HS_POL   = 1'b0;
    localparam bit c_VS_POL   = 1'b0;

    // Counter width; every axis total must fit below 2**c_CNT_W
    localparam int c_CNT_W    = 10;

    function automatic int calc_total(input int act, input int fp,
                                      input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic phase_t decode_phase(input logic [c_CNT_W-1:0] cnt,
                                            input int act, input int fp,
                                            input int sync);
        int c;
        c = int'(cnt);
        if (c < act)
            return ACTIVE;
        else if (c < act + fp)
            return FRONT;
        else if (c < act + fp + sync)
            return SYNC;
        return BACK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_ctrl_if
//  Purpose  : Run/Busy handshake plus raster timing outputs between the
//             timing sequencer (master) and the pixel generator (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_ctrl_if;
    logic       Run;
    logic       Busy;
    logic       PixTick;
    logic       HSync;
    logic       VSync;
    logic       DispEn;
    logic [9:0] PixX;
    logic [9:0] PixY;
    logic       LineStart;
    logic       FrameStart;

    modport master (
        input  Run,
        output Busy, PixTick, HSync, VSync, DispEn, PixX, PixY,
               LineStart, FrameStart
    );

    modport slave (
        output Run,
        input  Busy, PixTick, HSync, VSync, DispEn, PixX, PixY,
               LineStart, FrameStart
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_ctrl_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Purpose  : One raster axis: wrap counter over ACT+FP+SYNC+BP positions and
//             the phase decode of its next value (so callers can register
//             outputs on the same edge as the count).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACT_LEN  = c_H_ACTIVE,
    parameter int FP_LEN   = c_H_FP,
    parameter int SYNC_LEN = c_H_SYNC,
    parameter int BP_LEN   = c_H_BP
) (
    input  wire logic               CLK,
    input  wire logic               Reset_n,
    input  wire logic               i_clr,
    input  wire logic               i_en,
    output logic [c_CNT_W-1:0]      o_cnt_nxt,
    output phase_t                  o_phase_nxt,
    output logic                    o_wrap
);
    localparam int                 c_TOTAL = calc_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_TOTAL - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);
    assign o_wrap = i_en && w_last;

    // Next count: clear wins, otherwise advance and wrap when enabled
    always_comb begin
        o_cnt_nxt = r_cnt;
        if (i_clr)
            o_cnt_nxt = '0;
        else if (i_en)
            o_cnt_nxt = w_last ? '0 : r_cnt + c_CNT_W'(1);
    end

    // Count register
    always_ff @(posedge CLK) begin
        if (!Reset_n)
            r_cnt <= '0;
        else
            r_cnt <= o_cnt_nxt;
    end

    assign o_phase_nxt = decode_phase(o_cnt_nxt, ACT_LEN, FP_LEN, SYNC_LEN);

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_ctrl
//  Purpose  : VGA raster sequencer. Horizontal/vertical counters decoded into
//             registered sync, display-enable, coordinate and start pulses,
//             with a Run/Busy handshake that only stops on a frame boundary.
//  Options  : VGA_PIX_DIV2_EN - divide CLK by 2 to form the pixel tick.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter bit HS_POL   = c_HS_POL,
    parameter bit VS_POL   = c_VS_POL
) (
    input  wire logic          CLK,
    input  wire logic          Reset_n,
    vga_timing_ctrl_if.master  bus
);
    localparam int c_H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (c_H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_timing_ctrl: horizontal total exceeds 1024");
    end
    if (c_V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_timing_ctrl: vertical total exceeds 1024");
    end

    ctrl_state_t        r_state, w_state_nxt;
    logic               w_tick, w_live, w_clr, w_h_en;
    logic               w_h_wrap, w_v_wrap;
    logic [c_CNT_W-1:0] w_hcnt_nxt, w_vcnt_nxt;
    phase_t             w_hph_nxt, w_vph_nxt;
    logic               w_disp;

    logic               r_busy, r_hsync, r_vsync, r_disp_en;
    logic [c_CNT_W-1:0] r_pix_x, r_pix_y;
    logic               r_line_start, r_frame_start;

`ifdef VGA_PIX_DIV2_EN
    logic r_div;

    // Pixel tick on every second CLK, first one on the second cycle after reset
    always_ff @(posedge CLK) begin
        if (!Reset_n)
            r_div <= 1'b0;
        else
            r_div <= ~r_div;
    end

    assign w_tick = r_div;
`else
    assign w_tick = 1'b1;
`endif

    // Counters advance only while running; entering or sitting in IDLE holds them at 0
    assign w_live = (w_state_nxt != IDLE);
    assign w_clr  = ~w_live;
    assign w_h_en = w_tick && (r_state != IDLE);

    vga_axis_counter #(
        .ACT_LEN (H_ACTIVE), .FP_LEN (H_FP), .SYNC_LEN (H_SYNC), .BP_LEN (H_BP)
    ) u_h_axis (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .i_clr      (w_clr),
        .i_en       (w_h_en),
        .o_cnt_nxt  (w_hcnt_nxt),
        .o_phase_nxt(w_hph_nxt),
        .o_wrap     (w_h_wrap)
    );

    vga_axis_counter #(
        .ACT_LEN (V_ACTIVE), .FP_LEN (V_FP), .SYNC_LEN (V_SYNC), .BP_LEN (V_BP)
    ) u_v_axis (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .i_clr      (w_clr),
        .i_en       (w_h_wrap),
        .o_cnt_nxt  (w_vcnt_nxt),
        .o_phase_nxt(w_vph_nxt),
        .o_wrap     (w_v_wrap)
    );

    // Control state register
    always_ff @(posedge CLK) begin
        if (!Reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state: Run sampled on ticks; DRAIN leaves only at the last tick of a frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_tick && bus.Run)  w_state_nxt = RUN;
            RUN:     if (w_tick && !bus.Run) w_state_nxt = DRAIN;
            DRAIN: begin
                if (w_tick) begin
                    if (bus.Run)
                        w_state_nxt = RUN;
                    else if (w_v_wrap)
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_disp = w_live && (w_hph_nxt == ACTIVE) && (w_vph_nxt == ACTIVE);

    // Output registers, loaded from the next counter values so they track the counters
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_busy        <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_disp_en     <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_busy        <= w_live;
            r_hsync       <= (w_live && (w_hph_nxt == SYNC)) ? HS_POL : ~HS_POL;
            r_vsync       <= (w_live && (w_vph_nxt == SYNC)) ? VS_POL : ~VS_POL;
            r_disp_en     <= w_disp;
            r_pix_x       <= w_disp ? w_hcnt_nxt : '0;
            r_pix_y       <= w_disp ? w_vcnt_nxt : '0;
            r_line_start  <= w_tick && w_live && (w_hcnt_nxt == '0);
            r_frame_start <= w_tick && w_live && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
        end
    end

    assign bus.Busy       = r_busy;
    assign bus.PixTick    = w_tick;
    assign bus.HSync      = r_hsync;
    assign bus.VSync      = r_vsync;
    assign bus.DispEn     = r_disp_en;
    assign bus.PixX       = r_pix_x;
    assign bus.PixY       = r_pix_y;
    assign bus.LineStart  = r_line_start;
    assign bus.FrameStart = r_frame_start;

endmodule
`default_nettype wire

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the VGA raster: owns the horizontal and vertical pixel/line counters and decodes them into sync, display-enable and pixel-coordinate outputs. It adds a Run/Busy start-stop handshake so a display only stops on a frame boundary. Sits between the board clock and the pixel-generation logic on the DE0-CV VGA path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)
- CLK  in  1  sole clock, rising edge
- Reset_n  in  1  synchronous, active-low reset
- Run  in  1  level request: 1 = generate frames, 0 = stop at the next frame end
- Busy  out  1  1 while not IDLE
- PixTick  out  1  pixel-advance strobe, one CLK wide
- HSync / VSync  out  1  sync outputs at HS_POL / VS_POL when active
- DispEn  out  1  1 inside the visible area
- PixX / PixY  out  10  visible coordinate; 0 when DispEn = 0
- LineStart / FrameStart  out  1  one-CLK pulse when hcnt (resp. hcnt and vcnt) becomes 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Elaboration error if either total exceeds 1024.
- hcnt counts 0..H_TOTAL-1 on each tick and wraps to 0. vcnt increments when hcnt wraps, 0..V_TOTAL-1, and wraps to 0.
- Horizontal phase: ACTIVE [0,H_ACTIVE), FRONT, SYNC [H_ACTIVE+H_FP, +H_SYNC), BACK. Vertical phase is decoded the same way from vcnt.
- HSync is at the active level in horizontal SYNC; VSync at the active level in vertical SYNC. DispEn = hACTIVE and vACTIVE. PixX = hcnt and PixY = vcnt when DispEn = 1.
- Control FSM:
  - IDLE: counters held at 0, syncs inactive, DispEn 0. Run = 1 at a tick -> RUN. On that edge, outputs take the (0,0) decode and FrameStart and LineStart pulse.
  - RUN: counters advance. Run = 0 -> DRAIN.
  - DRAIN: counters advance. Run = 1 -> RUN, with no disturbance to the counters. At a tick with hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1 -> IDLE, counters go to 0 and outputs to idle values. If Run = 1 on that same tick, go to RUN instead (the frame continues).
- A frame in progress is never truncated except by reset.

## Timing
- All outputs are registered and update on the same edge as the counters: after the edge where hcnt becomes h, the outputs reflect h. There is no additional pipeline latency.
- Reset values: hcnt = vcnt = 0, state IDLE, Busy 0, HSync = ~HS_POL, VSync = ~VS_POL, DispEn 0, PixX = PixY = 0, LineStart = FrameStart = 0, divider toggle 0.
- Reset_n = 0 mid-frame: all outputs go to their reset values at the next edge, regardless of state. Reset has priority over Run.
- Run is sampled only on tick cycles.
- Default frame = 420000 ticks. HSync active at hcnt 656..751; VSync active at vcnt 490..491.

## Configuration
- VGA_PIX_DIV2_EN defined: an internal toggle flop divides CLK by 2 (50 MHz -> 25 MHz). PixTick is high on alternate CLK cycles, with the first tick on the second cycle after reset release. Counters, the FSM and the pulses advance only on tick cycles. Start pulses last one CLK.
- Not defined: CLK is the pixel clock. PixTick is tied to 1 and every cycle is a tick.

## Structure
- Package vga_timing_pkg contains:
  - the phase enum (ACTIVE/FRONT/SYNC/BACK);
  - the ctrl state enum (IDLE/RUN/DRAIN);
  - the 640x480@60 default constants;
  - a function computing totals.
- Sub-module vga_axis_counter holds one wrap counter plus its phase decoder, parameterised by the four segment lengths. It has a count-enable input and a wrap output, and is instantiated once for horizontal and once for vertical.

## Test plan
- Reset then Run = 1: FrameStart pulses once. After 800 ticks LineStart pulses again. After 420000 ticks FrameStart pulses again.
- Line check: HSync low exactly for hcnt 656..751 (96 ticks). DispEn high for 640 ticks per visible line. PixX runs 0..639.
- Frame check: VSync low for vcnt 490..491. DispEn is never high for vcnt ≥ 480. PixY reaches 479.
- Drop Run at vcnt = 100: Busy stays 1 through vcnt 524 / hcnt 799, then goes to 0 with outputs idle. Re-raising Run at vcnt = 300 in DRAIN keeps counting with no FrameStart.
- Reset_n = 0 for one cycle at vcnt = 250: the next edge shows all reset values. Busy 0 until Run is sampled again.
- With VGA_PIX_DIV2_EN: PixTick alternates 0/1 and hcnt advances every second CLK. HSync width = 192 CLK.
